// File: rtl/div_iter_unit.sv
// rtl/div_iter_unit.sv - radix-2 restoring divider for MIPS DIV/DIVU (optional: DIV_ZERO_FAST_EN)
module div_iter_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             stall,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

`ifdef DIV_ZERO_FAST_EN
  localparam bit ZERO_FAST = 1'b1;
`else
  localparam bit ZERO_FAST = 1'b0;
`endif

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] rem, quo, dvs, dvd_raw;
  logic             neg_q, neg_r, div_zero;
  logic [CNT_W-1:0] count;

  logic [WIDTH:0]   rem_sh, diff;
  logic [WIDTH-1:0] rem_next, quo_next, q_fix, r_fix;

  assign stall = (state == IDLE && start && !cancel) || (state == BUSY);

  // One restoring step; rem_sh needs WIDTH+1 bits since rem can approach the divisor.
  always_comb begin
    rem_sh = {rem, quo[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs};
    if (!diff[WIDTH]) begin
      rem_next = diff[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = rem_sh[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
    q_fix = div_zero ? '1 : (neg_q ? -quo_next : quo_next);
    r_fix = div_zero ? dvd_raw : (neg_r ? -rem_next : rem_next);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      ready     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      count     <= '0;
      rem       <= '0;
      quo       <= '0;
      dvs       <= '0;
      dvd_raw   <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready <= 1'b0;
          if (start && !cancel) begin
            quo      <= (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
            dvs      <= (is_signed && divisor[WIDTH-1]) ? -divisor : divisor;
            dvd_raw  <= dividend;
            neg_q    <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r    <= is_signed && dividend[WIDTH-1];
            div_zero <= (divisor == '0);
            rem      <= '0;
            count    <= '0;
            if (ZERO_FAST && divisor == '0) begin
              state     <= DONE;
              ready     <= 1'b1;
              quotient  <= '1;
              remainder <= dividend;
            end else begin
              state <= BUSY;
              busy  <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (cancel) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            rem   <= rem_next;
            quo   <= quo_next;
            count <= count + 1'b1;
            if (count == LAST) begin
              state     <= DONE;
              busy      <= 1'b0;
              ready     <= 1'b1;
              quotient  <= q_fix;
              remainder <= r_fix;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          ready <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
